// File: rtl/branch_predict_unit.sv
// ID-stage branch resolver for all six RV32I conditional branches, with an optional
// bimodal table of 2-bit counters read in IF and trained when a branch resolves in ID.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 64,
  parameter int PRED_MODE = 1,
  parameter int IMM_SHIFT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  input  logic             id_valid_i,
  input  logic             stall_i,
  input  logic             Branch_i,
  input  logic [2:0]       funct3_i,
  input  logic             id_pred_taken_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [XLEN-1:0]  PC_i,
  output logic             Flush_o,
  output logic [XLEN-1:0]  PC_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             resolve;
  logic             taken;
  logic             legal;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fall_through;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;

  assign resolve = id_valid_i & Branch_i & ~stall_i;
  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign id_idx  = PC_i[IDX_W+1:2];

  // funct3 010/011 are not branches: treat as not-taken and keep them out of the table
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3_i)
      3'b000:  taken = (RS1data_i == RS2data_i);
      3'b001:  taken = (RS1data_i != RS2data_i);
      3'b100:  taken = ($signed(RS1data_i) <  $signed(RS2data_i));
      3'b101:  taken = ($signed(RS1data_i) >= $signed(RS2data_i));
      3'b110:  taken = (RS1data_i <  RS2data_i);
      3'b111:  taken = (RS1data_i >= RS2data_i);
      default: legal = 1'b0;
    endcase
  end

  assign target       = PC_i + (Imm_i << IMM_SHIFT);
  assign fall_through = PC_i + XLEN'(4);
  assign Flush_o      = resolve & (taken ^ id_pred_taken_i);
  assign PC_o         = taken ? target : fall_through;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (resolve) begin
      branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (Flush_o) begin
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      end
    end
  end

  generate
    if (PRED_MODE != 0) begin : g_bht
      logic [1:0] bht [DEPTH];

      // Reset to weak-not-taken so one taken outcome is enough to flip the prediction
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            bht[i] <= 2'b01;
          end
        end else if (resolve && legal) begin
          if (taken && (bht[id_idx] != 2'b11)) begin
            bht[id_idx] <= bht[id_idx] + 2'b01;
          end else if (!taken && (bht[id_idx] != 2'b00)) begin
            bht[id_idx] <= bht[id_idx] - 2'b01;
          end
        end
      end

      assign pred_taken_o = bht[if_idx][1];
    end else begin : g_static
      logic unused_static;
      assign unused_static = ^{if_idx, id_idx, legal};
      assign pred_taken_o  = 1'b0;
    end
  endgenerate

  logic unused_pc;
  assign unused_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a bimodal and a static-mode instance share stimulus and are
// compared against a counter-array reference model, using directed steps then random traffic.
module tb_branch_predict_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [XLEN-1:0]   if_pc_i;
  logic              id_valid_i, stall_i, Branch_i, id_pred_taken_i;
  logic [2:0]        funct3_i;
  logic [XLEN-1:0]   RS1data_i, RS2data_i, Imm_i, PC_i;

  logic              pred_taken, flush, pred_taken_s, flush_s;
  logic [XLEN-1:0]   pc_out, pc_out_s;
  logic [31:0]       branch_cnt, mispred_cnt, branch_cnt_s, mispred_cnt_s;

  int checks = 0;
  int errors = 0;

  // Reference state: one saturating counter per table slot plus expected statistics
  int          ctr [DEPTH];
  logic [31:0] m_bcnt, m_mcnt;

  always #5 clk_i = ~clk_i;

  branch_predict_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .PRED_MODE(1), .IMM_SHIFT(1), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i), .pred_taken_o(pred_taken),
    .id_valid_i(id_valid_i), .stall_i(stall_i), .Branch_i(Branch_i), .funct3_i(funct3_i),
    .id_pred_taken_i(id_pred_taken_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .Imm_i(Imm_i), .PC_i(PC_i), .Flush_o(flush), .PC_o(pc_out),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  branch_predict_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .PRED_MODE(0), .IMM_SHIFT(1), .CNT_W(32)) dut_static (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i), .pred_taken_o(pred_taken_s),
    .id_valid_i(id_valid_i), .stall_i(stall_i), .Branch_i(Branch_i), .funct3_i(funct3_i),
    .id_pred_taken_i(id_pred_taken_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .Imm_i(Imm_i), .PC_i(PC_i), .Flush_o(flush_s), .PC_o(pc_out_s),
    .branch_cnt_o(branch_cnt_s), .mispred_cnt_o(mispred_cnt_s)
  );

  function automatic int slot(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic m_legal(input logic [2:0] f3);
    return !(f3 == 3'd2 || f3 == 3'd3);
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return {1'b0, a} < {1'b0, b};
      3'd7: return {1'b0, a} >= {1'b0, b};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_resolve();
    return id_valid_i && Branch_i && !stall_i;
  endfunction

  function automatic logic m_flush();
    return m_resolve() && (m_taken(funct3_i, RS1data_i, RS2data_i) != id_pred_taken_i);
  endfunction

  function automatic logic [XLEN-1:0] m_next_pc();
    if (m_taken(funct3_i, RS1data_i, RS2data_i)) return PC_i + Imm_i * 2;
    return PC_i + 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) ctr[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // Drive one ID/IF cycle just after the falling edge and check everything visible before the update
  task automatic applyStimulus(input logic valid, input logic br, input logic stall, input logic [2:0] f3,
                               input logic pred, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ifpc);
    @(negedge clk_i);
    id_valid_i = valid; Branch_i = br; stall_i = stall; funct3_i = f3; id_pred_taken_i = pred;
    RS1data_i = a; RS2data_i = b; Imm_i = imm; PC_i = pc; if_pc_i = ifpc;
    #1;
    checkOutput("flush", flush, m_flush());
    checkOutput("flush_static", flush_s, m_flush());
    if (m_flush()) begin
      checkOutput("pc_redirect", pc_out, m_next_pc());
      checkOutput("pc_redirect_static", pc_out_s, m_next_pc());
    end
    checkOutput("pred_taken", pred_taken, ctr[slot(if_pc_i)] >= 2);
    checkOutput("pred_taken_static", pred_taken_s, 1'b0);
    checkOutput("branch_cnt", branch_cnt, m_bcnt);
    checkOutput("mispred_cnt", mispred_cnt, m_mcnt);
    checkOutput("branch_cnt_static", branch_cnt_s, m_bcnt);
    checkOutput("mispred_cnt_static", mispred_cnt_s, m_mcnt);
  endtask

  task automatic advance();
    logic t;
    int   s;
    @(posedge clk_i);
    if (m_resolve()) begin
      t = m_taken(funct3_i, RS1data_i, RS2data_i);
      m_bcnt = m_bcnt + 1;
      if (m_flush()) m_mcnt = m_mcnt + 1;
      if (m_legal(funct3_i)) begin
        s = slot(PC_i);
        ctr[s] = t ? ((ctr[s] < 3) ? ctr[s] + 1 : 3) : ((ctr[s] > 0) ? ctr[s] - 1 : 0);
      end
    end
  endtask

  task automatic step(input logic valid, input logic br, input logic stall, input logic [2:0] f3,
                      input logic pred, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ifpc);
    applyStimulus(valid, br, stall, f3, pred, a, b, imm, pc, ifpc);
    advance();
  endtask

  // Asynchronous reset asserted away from any clock edge, held across one rising edge
  task automatic pulseReset();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_pred", pred_taken, 1'b0);
    checkOutput("rst_branch_cnt", branch_cnt, 32'd0);
    checkOutput("rst_mispred_cnt", mispred_cnt, 32'd0);
    checkOutput("rst_mispred_cnt_static", mispred_cnt_s, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    logic [XLEN-1:0] a, b, imm, pc, ifpc;
    logic [XLEN-1:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'hFFFF_FFFC; pcs[4] = 32'h1F0;

    rst_i = 1'b0;
    id_valid_i = 0; Branch_i = 0; stall_i = 0; funct3_i = 0; id_pred_taken_i = 0;
    RS1data_i = 0; RS2data_i = 0; Imm_i = 0; PC_i = 0; if_pc_i = 32'h100;
    modelReset();
    #3;
    $display("[TB] reset state");
    checkOutput("init_pred", pred_taken, 1'b0);
    checkOutput("init_branch_cnt", branch_cnt, 32'd0);
    checkOutput("init_mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    $display("[TB] directed: beq mispredict and training");
    applyStimulus(1, 1, 0, 3'd0, 0, 5, 5, 32'h8, 32'h100, 32'h100);
    checkOutput("beq_flush", flush, 1'b1);
    checkOutput("beq_pc", pc_out, 32'h110);
    advance();
    applyStimulus(1, 1, 0, 3'd4, 0, 32'hFFFF_FFFF, 1, 32'h8, 32'h100, 32'h100);
    checkOutput("beq_trained_pred", pred_taken, 1'b1);
    checkOutput("beq_mispred_cnt", mispred_cnt, 32'd1);
    checkOutput("blt_flush", flush, 1'b1);
    advance();
    applyStimulus(1, 1, 0, 3'd6, 0, 32'hFFFF_FFFF, 1, 32'h8, 32'h100, 32'h100);
    checkOutput("bltu_flush", flush, 1'b0);
    checkOutput("bltu_pc", pc_out, 32'h104);
    advance();

    $display("[TB] directed: saturation at 0x200");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 3'd1, 1, 1, 2, 32'h10, 32'h200, 32'h200);
    step(1, 1, 0, 3'd1, 1, 3, 3, 32'h10, 32'h200, 32'h200);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h200, 32'h200);
    checkOutput("sat_pred", pred_taken, 1'b1);
    advance();

    $display("[TB] directed: stall blocks updates");
    applyStimulus(1, 1, 1, 3'd0, 0, 7, 7, 32'h20, 32'h300, 32'h300);
    checkOutput("stall_flush", flush, 1'b0);
    advance();
    applyStimulus(1, 1, 0, 3'd0, 0, 7, 7, 32'h20, 32'h300, 32'h300);
    checkOutput("unstall_flush", flush, 1'b1);
    advance();
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h300, 32'h300);
    advance();

    $display("[TB] directed: static mode and illegal funct3");
    pulseReset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 0, 9, 9, 32'h40, 32'h400, 32'h400);
    applyStimulus(1, 1, 0, 3'd2, 1, 1, 1, 32'h40, 32'h400, 32'h400);
    checkOutput("static_pred", pred_taken_s, 1'b0);
    checkOutput("static_mispred_cnt", mispred_cnt_s, 32'd3);
    checkOutput("illegal_flush", flush_s, 1'b1);
    checkOutput("illegal_pc", pc_out_s, 32'h404);
    advance();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      if (n == 200) pulseReset();
      a    = $urandom();
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 3);
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      imm  = ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 8191)) - 4096) : $urandom();
      pc   = ($urandom_range(0, 2) != 0) ? pcs[$urandom_range(0, 4)] : ($urandom() & 32'hFFFF_FFFC);
      ifpc = ($urandom_range(0, 1) == 1) ? pc : pcs[$urandom_range(0, 4)];
      step($urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b, imm, pc, ifpc);
    end
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Next-generation ID-stage branch unit for the 5-stage RISC-V pipeline. It resolves all six RV32I conditional branches (beq/bne/blt/bge/bltu/bgeu) instead of beq only.
- It adds a parametrised bimodal branch history table (BHT) of 2-bit saturating counters. The table is read in IF and updated when the branch resolves in ID.
- It raises flush and redirect only on a misprediction, and keeps free-running branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath and PC width.
- DEPTH, 64, BHT entries; must be a power of 2, minimum 2. IDX_W = clog2(DEPTH).
- PRED_MODE, 1: 0 = static not-taken (BHT unused, never updated); 1 = bimodal BHT.
- IMM_SHIFT, 1, left shift applied to Imm_i when forming the target.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_pc_i  in  XLEN  PC of the instruction in IF (BHT lookup).
- pred_taken_o  out  1  IF prediction; combinational from the BHT.
- id_valid_i  in  1  ID holds a valid instruction.
- stall_i  in  1  ID stalled this cycle (hazard); blocks all state updates.
- Branch_i  in  1  ID instruction is a conditional branch.
- funct3_i  in  3  branch funct3 of the ID instruction.
- id_pred_taken_i  in  1  prediction carried from IF with this instruction.
- RS1data_i  in  XLEN  rs1 operand (post-forwarding).
- RS2data_i  in  XLEN  rs2 operand (post-forwarding).
- Imm_i  in  XLEN  sign-extended branch immediate.
- PC_i  in  XLEN  PC of the ID instruction.
- Flush_o  out  1  mispredict; flush IF/ID and redirect the PC.
- PC_o  out  XLEN  correct next PC for the redirect.
- branch_cnt_o  out  CNT_W  resolved branches.
- mispred_cnt_o  out  CNT_W  mispredicted branches.

Behaviour:
- resolve = id_valid_i & Branch_i & ~stall_i.
- taken by funct3:
  - 000: eq.
  - 001: ne.
  - 100: signed lt.
  - 101: signed ge.
  - 110: unsigned lt.
  - 111: unsigned ge.
  - 010/011: illegal; taken = 0, BHT update suppressed, stats still counted.
- target = PC_i + (Imm_i << IMM_SHIFT), truncated to XLEN (wraps mod 2^XLEN). Fall-through = PC_i + 4, also wrapping.
- Flush_o = resolve & (taken != id_pred_taken_i), combinational.
- PC_o = taken ? target : fall-through. PC_o is meaningful only while Flush_o = 1.
- BHT index:
  - IF lookup uses if_pc_i[IDX_W+1:2].
  - Update uses PC_i[IDX_W+1:2].
  - Upper PC bits alias (no tags).
- pred_taken_o = BHT[index][1] in PRED_MODE=1; constant 0 in PRED_MODE=0.
- BHT update on the rising edge when resolve (and the funct3 is legal, PRED_MODE=1):
  - taken: counter += 1, saturating at 3.
  - not taken: counter -= 1, saturating at 0.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Same-cycle lookup and update to the same index: pred_taken_o shows the pre-update value. The new value is visible the next cycle.
- Stats on the rising edge when resolve:
  - branch_cnt_o += 1.
  - mispred_cnt_o += 1 if Flush_o.
  - Both wrap mod 2^CNT_W.
- stall_i = 1 or id_valid_i = 0: Flush_o = 0, no BHT update, no stats update.
- Reset (rst_i = 0, any time, asynchronous):
  - All BHT entries go to 01; stats go to 0.
  - pred_taken_o = 0, because every entry reads 01.
  - Flush_o stays purely combinational from its inputs.
- Reset asserted mid-stream discards all history. The first branch after release is predicted not-taken.
- Combinational paths from inputs to Flush_o/PC_o carry no latency. The prediction effect of an update appears 1 cycle later.

Test Plan:
- Reset, then if_pc_i = 0x100 -> pred_taken_o = 0, branch_cnt_o = 0, mispred_cnt_o = 0.
- beq, RS1 = RS2 = 5, PC_i = 0x100, Imm_i = 0x8, id_pred_taken_i = 0 -> Flush_o = 1, PC_o = 0x110. Next cycle: BHT[0] = 10 and pred_taken_o for if_pc_i = 0x100 is 1; mispred_cnt_o = 1.
- blt with RS1 = 0xFFFFFFFF, RS2 = 1 -> taken. bltu with the same operands -> not taken. With id_pred_taken_i = 0 on both: Flush_o 1 then 0, PC_o = 0x104 on the bltu, PC_i = 0x100.
- Four taken bne at PC 0x200 -> counter saturates at 11. One not-taken -> 10, pred_taken_o still 1.
- stall_i = 1 with a mispredicting branch -> Flush_o = 0 and counters unchanged. Drop stall -> Flush_o = 1 and counters increment once.
- PRED_MODE = 0: 3 taken branches -> pred_taken_o stays 0 and every branch flushes (mispred_cnt_o = 3). Also funct3 = 010 with id_pred_taken_i = 1 -> Flush_o = 1, PC_o = PC_i + 4.
